// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 round controller feeding an external round datapath.
module aes_round_sequencer #(
  parameter int ROUND_LAT = 3
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic [127:0] rnd_din,
  output logic [3:0]   rnd_count,
  output logic [127:0] rnd_kin,
  output logic         rnd_last,
  input  logic [127:0] rnd_out,
  input  logic [127:0] rnd_kout,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic [127:0] ct_data
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] LAT_M1 = 4'(ROUND_LAT - 1);
  state_t state, state_nxt;
  logic [127:0] state_reg, key_reg, ct_reg;
  logic [3:0] round, wait_cnt;
  logic accept, round_end, final_end;
  assign accept    = (state == IDLE) && in_valid;
  assign round_end = (state == RUN) && (wait_cnt == LAT_M1);
  assign final_end = round_end && (round == 4'd10);
  assign in_ready  = (state == IDLE);
  assign ct_valid  = (state == DONE);
  assign ct_data   = ct_reg;
  assign rnd_din   = state_reg;
  assign rnd_kin   = key_reg;
  assign rnd_count = round;
  assign rnd_last  = (round == 4'd10);
  always_ff @(posedge clock)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = accept ? RUN :
                final_end ? DONE :
                (state == DONE && ct_ready) ? IDLE : state;
  end
  // Round inputs are only ever updated on a round boundary, so they stay constant across each window.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      ct_reg    <= '0;
      round     <= '0;
      wait_cnt  <= '0;
    end else if (accept) begin
      state_reg <= in_pt ^ in_key;
      key_reg   <= in_key;
      round     <= 4'd1;
      wait_cnt  <= '0;
    end else if (final_end) begin
      ct_reg   <= rnd_out;
      wait_cnt <= '0;
    end else if (round_end) begin
      state_reg <= rnd_out;
      key_reg   <= rnd_kout;
      round     <= round + 4'd1;
      wait_cnt  <= '0;
    end else if (state == RUN) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: random and FIPS-197 vectors against a behavioural AES round model.
module tb_aes_round_sequencer;
  localparam int L = 3;
  logic clock = 0;
  always #5 clock = ~clock;
  logic rst, in_valid, in_ready, ct_valid, ct_ready, rnd_last;
  logic [127:0] in_pt, in_key, rnd_din, rnd_kin, rnd_out, rnd_kout, ct_data;
  logic [3:0] rnd_count;
  logic in_valid1, in_ready1, ct_valid1, rnd_last1;
  logic [127:0] in_pt1, in_key1, rnd_din1, rnd_kin1, rnd_out1, rnd_kout1, ct_data1;
  logic [3:0] rnd_count1;
  int checks = 0, failures = 0;
  logic [7:0] sbox [256];

  aes_round_sequencer #(.ROUND_LAT(L)) dut (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pt(in_pt), .in_key(in_key), .rnd_din(rnd_din), .rnd_count(rnd_count),
    .rnd_kin(rnd_kin), .rnd_last(rnd_last), .rnd_out(rnd_out), .rnd_kout(rnd_kout),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data));

  aes_round_sequencer #(.ROUND_LAT(1)) dut1 (
    .clock(clock), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_pt(in_pt1), .in_key(in_key1), .rnd_din(rnd_din1), .rnd_count(rnd_count1),
    .rnd_kin(rnd_kin1), .rnd_last(rnd_last1), .rnd_out(rnd_out1), .rnd_kout(rnd_kout1),
    .ct_valid(ct_valid1), .ct_ready(1'b1), .ct_data(ct_data1));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox[s[127-8*(r+4*((c+r)%4)) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
      o[103-32*c -: 8] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0] rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xt(rc);
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
    w0 ^= t; w1 ^= w0; w2 ^= w1; w3 ^= w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k, input int r, input logic last);
    logic [127:0] t = sub_shift(s);
    if (!last) t = mix(t);
    return t ^ key_step(k, r);
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ key, k = key;
    for (int r = 1; r <= 10; r++) begin
      s = round_fn(s, k, r, r == 10);
      k = key_step(k, r);
    end
    return s;
  endfunction

  initial begin
    logic [7:0] p;
    logic [15:0] d;
    for (int i = 0; i < 256; i++) begin
      p = 8'h01;
      for (int j = 0; j < 254; j++) p = gmul(p, 8'(i));
      d = {p, p};
      sbox[i] = p ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    end
  end

  // Round datapath model: outputs are garbage until the inputs have been stable for ROUND_LAT cycles.
  int stab = 0;
  logic [127:0] pd = 0, pk = 0;
  logic [3:0] pc = 0;
  always @(negedge clock) begin
    stab = ({rnd_din, rnd_kin, rnd_count} == {pd, pk, pc}) ? stab + 1 : 0;
    pd = rnd_din; pk = rnd_kin; pc = rnd_count;
    rnd_out  <= (stab >= L - 1) ? round_fn(rnd_din, rnd_kin, int'(rnd_count), rnd_last) : ~round_fn(rnd_din, rnd_kin, int'(rnd_count), rnd_last);
    rnd_kout <= (stab >= L - 1) ? key_step(rnd_kin, int'(rnd_count)) : ~key_step(rnd_kin, int'(rnd_count));
    rnd_out1  <= round_fn(rnd_din1, rnd_kin1, int'(rnd_count1), rnd_last1);
    rnd_kout1 <= key_step(rnd_kin1, int'(rnd_count1));
  end

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_ct_data", ct_data, 0);
    chk("rst_rnd_din", rnd_din, 0);
    chk("rst_rnd_kin", rnd_kin, 0);
    chk("rst_rnd_count", rnd_count, 0);
    chk("rst_rnd_last", rnd_last, 0);
  endtask

  task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input logic nv,
                           input logic [127:0] nkey, input logic [127:0] npt, input int hold);
    logic [127:0] exp = aes_encrypt(pt, key);
    int w = 0;
    in_key = key; in_pt = pt; in_valid = 1;
    while (!in_ready && w < 100) begin @(negedge clock); w++; end
    chk("accept_wait", w, 0);
    ct_ready = (hold == 0);
    @(negedge clock);
    in_valid = nv; in_key = nkey; in_pt = npt;
    for (int n = 1; n <= 10 * L; n++) begin
      int r = (n - 1) / L + 1;
      chk("rnd_count", rnd_count, r);
      chk("rnd_last", rnd_last, r == 10);
      chk("ct_valid_early", ct_valid, 0);
      chk("in_ready_run", in_ready, 0);
      if (n == 1) begin
        chk("rnd_din_r1", rnd_din, pt ^ key);
        chk("rnd_kin_r1", rnd_kin, key);
      end
      @(negedge clock);
    end
    chk("ct_valid_rise", ct_valid, 1);
    chk("ct_data", ct_data, exp);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_ct_valid", ct_valid, 1);
      chk("hold_ct_data", ct_data, exp);
      chk("hold_in_ready", in_ready, 0);
    end
    ct_ready = 1;
    @(negedge clock);
    chk("post_in_ready", in_ready, 1);
    chk("post_ct_valid", ct_valid, 0);
    chk("post_ct_data", ct_data, exp);
  endtask

  initial begin
    int n, seen;
    logic [127:0] ka, pa, kb, pb;
    rst = 1; in_valid = 0; in_pt = 0; in_key = 0; ct_ready = 1;
    in_valid1 = 0; in_pt1 = 0; in_key1 = 0;
    repeat (3) @(negedge clock);
    chk_reset();
    rst = 0;
    @(negedge clock);
    run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 0, 0, 0, 0);
    chk("fips_c1", ct_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    // ROUND_LAT=1 instance: one cycle per round.
    in_key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    in_pt1  = 128'h3243f6a8885a308d313198a2e0370734;
    in_valid1 = 1;
    @(negedge clock);
    in_valid1 = 0;
    n = 1;
    while (!ct_valid1 && n < 40) begin @(negedge clock); n++; end
    chk("lat1_cycles", n - 1, 10);
    chk("lat1_ct_data", ct_data1, 128'h3925841d02dc09fbdc118597196a0b32);
    ka = {$urandom, $urandom, $urandom, $urandom};
    pa = {$urandom, $urandom, $urandom, $urandom};
    run_block(ka, pa, 0, 0, 0, 20);
    ka = {$urandom, $urandom, $urandom, $urandom};
    pa = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    run_block(ka, pa, 1, kb, pb, 0);
    run_block(kb, pb, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, i);
    in_key = {$urandom, $urandom, $urandom, $urandom};
    in_pt  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1;
    @(negedge clock);
    in_valid = 0;
    repeat (4 * L) @(negedge clock);
    chk("mid_round5", rnd_count, 5);
    rst = 1;
    @(negedge clock);
    rst = 0;
    chk_reset();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ct_valid) seen++;
    end
    chk("no_ct_after_rst", seen, 0);
    run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 0, 0, 0, 0);
    chk("fips_b", ct_data, 128'h3925841d02dc09fbdc118597196a0b32);
    rst = 1; in_valid = 1;
    @(negedge clock);
    chk("rst_acc_in_ready", in_ready, 1);
    chk("rst_acc_count", rnd_count, 0);
    chk("rst_acc_ct_valid", ct_valid, 0);
    rst = 0; in_valid = 0;
    @(negedge clock);
    chk("rst_acc_idle", in_ready, 1);
    chk("rst_acc_count2", rnd_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES-128 encryption controller that sits directly upstream of the round datapath stages (the middle-round stage and the final-round stage). Accepts a plaintext/cipher-key pair over a valid/ready handshake and performs the initial AddRoundKey. It then sequences rounds 1–10 through the round datapath, feeding each round's state and key back, and presents the ciphertext on a valid/ready output. Round datapath latency is a parameter, so the sequencer tracks changes in datapath pipelining.

## Interface
- ROUND_LAT, 3, clock cycles from stable round inputs to valid round outputs; legal range 1–15.
- clock  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext/key pair offered.
- in_ready  out  1  sequencer can accept a pair.
- in_pt  in  128  plaintext, byte 0 in [127:120].
- in_key  in  128  cipher key, same byte order.
- rnd_din  out  128  state to round datapath.
- rnd_count  out  4  current round number, 1–10.
- rnd_kin  out  128  previous round key (cipher key for round 1).
- rnd_last  out  1  selects final-round stage (no MixColumns); high only in round 10.
- rnd_out  in  128  round result from selected stage.
- rnd_kout  in  128  round key generated for rnd_count.
- ct_valid  out  1  ciphertext available.
- ct_ready  in  1  consumer accepts ciphertext.
- ct_data  out  128  ciphertext.

## Operation
- States:
  - IDLE: in_ready=1. An accept (in_valid&in_ready) loads state_reg=in_pt^in_key, key_reg=in_key, round=1, wait_cnt=0, then goes to RUN.
  - RUN: in_ready=0. Driven outputs are rnd_din=state_reg, rnd_kin=key_reg, rnd_count=round and rnd_last=(round==10). All are registered and held constant for the whole round window.
    - wait_cnt increments each cycle.
    - When wait_cnt==ROUND_LAT-1 and round<10: state_reg←rnd_out, key_reg←rnd_kout, round←round+1, wait_cnt←0.
    - When wait_cnt==ROUND_LAT-1 and round==10: ct_reg←rnd_out, go to DONE.
  - DONE: ct_valid=1, ct_data=ct_reg. Output is held until ct_valid&ct_ready, then the sequencer returns to IDLE.
- in_valid is ignored outside IDLE; no queuing.
- There is no bypass from DONE to RUN. A new pair can be accepted no earlier than the cycle after the ciphertext handshake.
- ct_data is stable while ct_valid=1. ct_data keeps its last value after the handshake.
- Register widths:
  - wait_cnt: 4 bits.
  - round: 4 bits, never exceeds 10.
- No other arithmetic is performed; only XOR and capture.

## Timing
- Reset (any state, including mid-RUN or DONE) takes effect on the next edge and sets:
  - state IDLE, in_ready=1, ct_valid=0.
  - ct_data=0, rnd_din=0, rnd_kin=0.
  - rnd_count=0, rnd_last=0, round=0, wait_cnt=0.
  - Any in-flight block is discarded and no ct_valid is produced for it.
- Reset has priority over an accept or output handshake in the same cycle.
- Latency, with E0 the accept edge:
  - Round r inputs are driven from E0+(r-1)·ROUND_LAT and captured at E0+r·ROUND_LAT.
  - ct_valid rises at E0+10·ROUND_LAT (30 cycles at default).
- Throughput, back-to-back with ct_ready=1: one block per 10·ROUND_LAT+2 cycles. The extra cycles are one DONE cycle and one IDLE cycle.
- ROUND_LAT=1: each round lasts exactly one cycle and wait_cnt stays 0.
- in_ready and ct_valid are never high in the same cycle.

## Test plan
- Bench datapath is a behavioural AES round/key-schedule model with ROUND_LAT delay.
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: ct_data=69c4e0d86a7b0430d8cdb78070b4c55a with ct_valid rising exactly 30 cycles after accept.
  - Checks at each round: rnd_count steps 1..10 and rnd_last is high only in round 10.
- Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, ROUND_LAT=1 -> ct_data=3925841d02dc09fbdc118597196a0b32, 10 cycles after accept.
- Backpressure: ct_ready=0 for 20 cycles after ct_valid rises. ct_valid and ct_data must stay stable and in_ready must stay 0 throughout. Then raise ct_ready for one cycle: the sequencer returns to IDLE and in_ready=1 on the next cycle.
- in_valid held high with a different pair throughout RUN -> no effect on the ciphertext. The second pair is accepted on the first IDLE cycle, and the two blocks' ciphertexts come out in order.
- Reset asserted for one cycle at round 5 -> all outputs return to their reset values on the next edge and no ct_valid appears. A subsequent FIPS-197 vector then encrypts correctly.
- Reset asserted in the same cycle as an accept -> the pair is not accepted; the sequencer stays in IDLE with in_ready=1.
